norm2_isqrt: RTL and testbench

//  Downstream stage of the norm2 accumulator (main). Consumes its signed 64-bit
//  sum-of-squares result on the w_enable pulse. Produces the Euclidean norm as

---
 rtl/norm2_pkg.sv | 16 +
 rtl/norm2_isqrt_step.sv | 37 +++
 rtl/norm2_isqrt.sv | 97 +++++++++
 tb/tb_norm2_isqrt.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/norm2_pkg.sv
// Shared constants for the norm2 square-root stage: widths and FSM state encodings.
package norm2_pkg;

  localparam int IN_W_DEF  = 64;
  localparam int OUT_W_DEF = IN_W_DEF / 2;
  localparam int CNT_W_DEF = $clog2(OUT_W_DEF + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int cnt_width(input int out_w);
    return $clog2(out_w + 1);
  endfunction

endpackage

// File: rtl/norm2_isqrt_step.sv
// One restoring square-root iteration: folds two radicand bits into the partial
// remainder and appends one bit to the partial root.
module norm2_isqrt_step
  import norm2_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [OUT_W+1:0] rem,
  input  logic [OUT_W-1:0] root,
  input  logic [1:0]       bits,
  output logic [OUT_W+1:0] rem_next,
  output logic [OUT_W-1:0] root_next
);

  logic [OUT_W+3:0] t_s;
  logic [OUT_W+3:0] trial_s;
  logic [OUT_W+3:0] diff_s;
  logic             unused_s;

  // Trial subtraction at full width; the kept remainder never exceeds 2*root.
  always_comb begin
    t_s      = {rem, bits};
    trial_s  = {2'b00, root, 2'b01};
    diff_s   = t_s - trial_s;
    if (t_s >= trial_s) begin
      rem_next  = diff_s[OUT_W+1:0];
      root_next = {root[OUT_W-2:0], 1'b1};
    end else begin
      rem_next  = t_s[OUT_W+1:0];
      root_next = {root[OUT_W-2:0], 1'b0};
    end
  end

  // These high bits are always zero given the bounded remainder and root.
  assign unused_s = ^{t_s[OUT_W+3:OUT_W+2], diff_s[OUT_W+3:OUT_W+2], root[OUT_W-1]};

endmodule

// File: rtl/norm2_isqrt.sv
// Sequential integer square root of a signed radicand, one root bit per cycle,
// with a start/done pulse handshake.
module norm2_isqrt
  import norm2_pkg::*;
#(
  parameter  int IN_W  = IN_W_DEF,
  localparam int OUT_W = IN_W / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r_enable,
  input  logic [IN_W-1:0]  x,
  output logic             w_enable,
  output logic [OUT_W-1:0] result,
  output logic [OUT_W:0]   remainder,
  output logic             neg_err,
  output logic             busy
);

  localparam int CNT_W = cnt_width(OUT_W);

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [IN_W-1:0]  radicand_r;
  logic [OUT_W+1:0] rem_r;
  logic [OUT_W-1:0] root_r;
  logic             neg_r;
  logic [OUT_W+1:0] rem_next_s;
  logic [OUT_W-1:0] root_next_s;

  norm2_isqrt_step #(
    .OUT_W (OUT_W)
  ) u_step (
    .rem       (rem_r),
    .root      (root_r),
    .bits      (radicand_r[IN_W-1 -: 2]),
    .rem_next  (rem_next_s),
    .root_next (root_next_s)
  );

  // FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      radicand_r <= '0;
      rem_r      <= '0;
      root_r     <= '0;
      neg_r      <= 1'b0;
      w_enable   <= 1'b0;
      result     <= '0;
      remainder  <= '0;
      neg_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      w_enable <= 1'b0;
      case (state_r)
        IDLE: begin
          if (r_enable) begin
            neg_r      <= x[IN_W-1];
            radicand_r <= x[IN_W-1] ? '0 : x;
            rem_r      <= '0;
            root_r     <= '0;
            cnt_r      <= '0;
            busy       <= 1'b1;
            state_r    <= CALC;
          end else begin
            busy <= 1'b0;
          end
        end
        CALC: begin
          rem_r      <= rem_next_s;
          root_r     <= root_next_s;
          radicand_r <= radicand_r << 2;
          if (cnt_r == CNT_W'(OUT_W - 1)) begin
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          // Busy stays high through the done cycle and drops once back in IDLE.
          w_enable  <= 1'b1;
          result    <= neg_r ? '0 : root_r;
          remainder <= neg_r ? '0 : rem_r[OUT_W:0];
          neg_err   <= neg_r;
          state_r   <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_norm2_isqrt.sv
// Directed self-checking bench for norm2_isqrt: latency, values, boundaries,
// negative input, ignored restarts, abort on reset and back-to-back operation.
module tb_norm2_isqrt;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_enable;
  logic [63:0] x;
  logic        w_enable;
  logic [31:0] result;
  logic [32:0] remainder;
  logic        neg_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  norm2_isqrt dut (
    .clk       (clk),
    .rst       (rst),
    .r_enable  (r_enable),
    .x         (x),
    .w_enable  (w_enable),
    .result    (result),
    .remainder (remainder),
    .neg_err   (neg_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Pulse r_enable with v, then return the cycle count to w_enable (0 = timeout).
  task automatic launch(input logic [63:0] v, output int lat);
    @(negedge clk);
    r_enable = 1'b1;
    x = v;
    @(negedge clk);
    r_enable = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (w_enable) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    r_enable = 1'b0;
    x = 64'd0;
    repeat (3) @(negedge clk);
    checks++; if (w_enable !== 1'b0) begin errors++; $display("FAIL reset_w_enable got %b want 0", w_enable); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %0d want 0", result); end
    checks++; if (remainder !== 33'd0) begin errors++; $display("FAIL reset_remainder got %0d want 0", remainder); end
    checks++; if (neg_err !== 1'b0) begin errors++; $display("FAIL reset_neg_err got %b want 0", neg_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    int lat;
    @(negedge clk);
    r_enable = 1'b1;
    x = 64'd0;
    @(negedge clk);
    r_enable = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL latency_busy_start got %b want 1", busy); end
      end
      if (w_enable) begin
        lat = k;
        break;
      end
    end
    checks++; if (lat !== 33) begin errors++; $display("FAIL latency_zero got %0d want 33", lat); end
    checks++; if (result !== 32'd0 || remainder !== 33'd0 || neg_err !== 1'b0) begin
      errors++; $display("FAIL zero_value got %0d/%0d/%b want 0/0/0", result, remainder, neg_err);
    end
    @(posedge clk); #1;
    checks++; if (w_enable !== 1'b0) begin errors++; $display("FAIL pulse_width got %b want 0", w_enable); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_idle got %b want 0", busy); end
  endtask

  task automatic test_values();
    logic [63:0] xs   [6] = '{64'd1000, 64'd1000000, 64'd2, 64'd3, 64'd15, 64'd4294967296};
    logic [31:0] ress [6] = '{32'd31, 32'd1000, 32'd1, 32'd1, 32'd3, 32'd65536};
    logic [32:0] rems [6] = '{33'd39, 33'd0, 33'd1, 33'd2, 33'd6, 33'd0};
    int lat;
    for (int i = 0; i < 6; i++) begin
      launch(xs[i], lat);
      checks++; if (lat !== 33) begin errors++; $display("FAIL value_latency x=%0d got %0d want 33", xs[i], lat); end
      checks++; if (result !== ress[i] || remainder !== rems[i]) begin
        errors++; $display("FAIL value x=%0d got %0d r%0d want %0d r%0d", xs[i], result, remainder, ress[i], rems[i]);
      end
    end
  endtask

  task automatic test_max();
    int lat;
    launch(64'h4000_0000_0000_0000, lat);
    checks++; if (lat !== 33 || result !== 32'h8000_0000 || remainder !== 33'd0) begin
      errors++; $display("FAIL pow62 got lat%0d %0d r%0d want lat33 2147483648 r0", lat, result, remainder);
    end
    launch(64'h7FFF_FFFF_FFFF_FFFF, lat);
    checks++; if (lat !== 33 || result !== 32'd3037000499 || remainder !== 33'd5928526806) begin
      errors++; $display("FAIL maxpos got lat%0d %0d r%0d want lat33 3037000499 r5928526806", lat, result, remainder);
    end
    checks++; if (neg_err !== 1'b0) begin errors++; $display("FAIL maxpos_neg_err got %b want 0", neg_err); end
  endtask

  task automatic test_negative();
    int lat;
    launch(64'hFFFF_FFFF_FFFF_FFFF, lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL neg_latency got %0d want 33", lat); end
    checks++; if (neg_err !== 1'b1 || result !== 32'd0 || remainder !== 33'd0) begin
      errors++; $display("FAIL neg_value got %b/%0d/%0d want 1/0/0", neg_err, result, remainder);
    end
    launch(64'd4, lat);
    checks++; if (lat !== 33 || neg_err !== 1'b0 || result !== 32'd2 || remainder !== 33'd0) begin
      errors++; $display("FAIL after_neg got lat%0d %b/%0d/%0d want lat33 0/2/0", lat, neg_err, result, remainder);
    end
  endtask

  task automatic test_ignore_restart();
    int pulses = 0;
    @(negedge clk);
    r_enable = 1'b1;
    x = 64'd105;
    @(negedge clk);
    x = 64'd49;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) begin
        checks++; if (result !== 32'd2) begin errors++; $display("FAIL hold_during_calc got %0d want 2", result); end
      end
      if (w_enable) pulses++;
      @(negedge clk);
      if (k == 20) r_enable = 1'b0;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL restart_pulses got %0d want 1", pulses); end
    checks++; if (result !== 32'd10 || remainder !== 33'd5) begin
      errors++; $display("FAIL restart_value got %0d r%0d want 10 r5", result, remainder);
    end
  endtask

  task automatic test_abort();
    int pulses = 0;
    @(negedge clk);
    r_enable = 1'b1;
    x = 64'd1000000;
    @(negedge clk);
    r_enable = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    r_enable = 1'b1;
    x = 64'd25;
    @(posedge clk); #1;
    checks++; if (w_enable !== 1'b0 || result !== 32'd0 || remainder !== 33'd0 || neg_err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_outputs got %b/%0d/%0d/%b/%b want 0/0/0/0/0", w_enable, result, remainder, neg_err, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    r_enable = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (w_enable) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_pulses got %0d want 0", pulses); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    launch(64'd1000, lat);
    checks++; if (lat !== 33 || result !== 32'd31 || remainder !== 33'd39) begin
      errors++; $display("FAIL b2b_first got lat%0d %0d r%0d want lat33 31 r39", lat, result, remainder);
    end
    launch(64'd15, lat);
    checks++; if (lat !== 33 || result !== 32'd3 || remainder !== 33'd6) begin
      errors++; $display("FAIL b2b_second got lat%0d %0d r%0d want lat33 3 r6", lat, result, remainder);
    end
  endtask

  task automatic test_property();
    logic [63:0] xs [5] = '{64'd12345678, 64'd1099511627783, 64'd999999999999,
                            64'd123456789012345, 64'h7FFF_FFFF_FFFF_FFFE};
    logic [65:0] lo;
    logic [65:0] hi;
    logic [65:0] xv;
    int lat;
    for (int i = 0; i < 5; i++) begin
      launch(xs[i], lat);
      xv = {2'b00, xs[i]};
      lo = {34'd0, result} * {34'd0, result};
      hi = ({34'd0, result} + 66'd1) * ({34'd0, result} + 66'd1);
      checks++; if (lat !== 33 || !(lo <= xv && xv < hi)) begin
        errors++; $display("FAIL prop_bound x=%0d got %0d lat%0d", xs[i], result, lat);
      end
      checks++; if ((xv - lo) !== {33'd0, remainder}) begin
        errors++; $display("FAIL prop_rem x=%0d got %0d want %0d", xs[i], remainder, xv - lo);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    r_enable = 1'b0;
    x = 64'd0;
    test_reset();
    test_latency();
    test_values();
    test_max();
    test_negative();
    test_ignore_restart();
    test_abort();
    test_back_to_back();
    test_property();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
